// File: rtl/lock_digit_entry.sv
// Debounced digit-entry stage: synchronizes the raw pushbutton and switch bank,
// debounces the button, and emits a one-cycle strobe carrying the captured digit.
module lock_digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] sw,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_illegal,
    output logic [2:0] press_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       PC_MAX   = 3'd6;

    logic             key_meta_reg;
    logic             key_s_reg;
    logic [3:0]       sw_s;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       digit_reg, digit_next;
    logic             digit_valid_reg, digit_valid_next;
    logic             digit_illegal_reg, digit_illegal_next;
    logic [2:0]       press_count_reg, press_count_next;

    // Button synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_meta_reg <= 1'b1;
            key_s_reg    <= 1'b1;
        end else begin
            key_meta_reg <= key_n;
            key_s_reg    <= key_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sw_s[gi] = sync_reg;
        end
    endgenerate

    // Starting in REL_CHK means a key held through reset must be released and re-pressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg         <= REL_CHK;
            cnt_reg           <= '0;
            digit_reg         <= 4'd0;
            digit_valid_reg   <= 1'b0;
            digit_illegal_reg <= 1'b0;
            press_count_reg   <= 3'd0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            digit_reg         <= digit_next;
            digit_valid_reg   <= digit_valid_next;
            digit_illegal_reg <= digit_illegal_next;
            press_count_reg   <= press_count_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        digit_next         = digit_reg;
        digit_valid_next   = 1'b0;
        digit_illegal_next = digit_illegal_reg;
        press_count_next   = press_count_reg;

        case (state_reg)
            IDLE: begin
                if (!key_s_reg) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (key_s_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next         = HELD;
                    digit_next         = sw_s;
                    digit_illegal_next = (sw_s > 4'd9);
                    digit_valid_next   = 1'b1;
                    press_count_next   = (press_count_reg >= PC_MAX) ? PC_MAX
                                                                     : press_count_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_s_reg) begin
                    state_next = REL_CHK;
                    cnt_next   = '0;
                end
            end
            REL_CHK: begin
                // A low glitch while releasing means the key is still held.
                if (!key_s_reg) begin
                    state_next = HELD;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign digit         = digit_reg;
    assign digit_valid   = digit_valid_reg;
    assign digit_illegal = digit_illegal_reg;
    assign press_count   = press_count_reg;

endmodule

// File: tb/tb_lock_digit_entry.sv
// Directed bench for lock_digit_entry with a short debounce window (4 cycles).
module tb_lock_digit_entry;

    logic       clk;
    logic       reset;
    logic       key_n;
    logic [3:0] sw;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_illegal;
    logic [2:0] press_count;

    int vectors;
    int miscompares;
    int tick_idx;
    int pulses;
    int first_tick;
    int cap_digit;
    int cap_ill;
    int cap_pc;

    lock_digit_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .sw           (sw),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .digit_illegal(digit_illegal),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        tick_idx   = 0;
        pulses     = 0;
        first_tick = -1;
    endtask

    // Advance n clock edges, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick_idx++;
            if (digit_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) first_tick = tick_idx;
                cap_digit = int'(digit);
                cap_ill   = int'(digit_illegal);
                cap_pc    = int'(press_count);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_valid"}, int'(digit_valid), 0);
        check({tag, "_illegal"}, int'(digit_illegal), 0);
        check({tag, "_count"}, int'(press_count), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cap_digit   = -1;
        cap_ill     = -1;
        cap_pc      = -1;
        reset       = 1'b0;
        key_n       = 1'b1;
        sw          = 4'd0;
        clear_mon();

        // Reset and first press
        tick(1);
        check_zero("rst1");
        tick(1);
        check_zero("rst2");
        reset = 1'b1;
        tick(6);
        sw    = 4'd3;
        key_n = 1'b0;
        clear_mon();
        tick(12);
        check("p1_pulses", pulses, 1);
        check("p1_latency", first_tick, 7);
        check("p1_digit", cap_digit, 3);
        check("p1_illegal", cap_ill, 0);
        check("p1_count", cap_pc, 1);
        check("p1_valid_low", int'(digit_valid), 0);
        check("p1_digit_held", int'(digit), 3);
        key_n = 1'b1;
        tick(10);

        // Press bounce
        sw    = 4'd9;
        key_n = 1'b0;
        clear_mon();
        tick(3);
        key_n = 1'b1;
        tick(1);
        check("bnc_early_pulses", pulses, 0);
        key_n = 1'b0;
        clear_mon();
        tick(12);
        check("bnc_pulses", pulses, 1);
        check("bnc_latency", first_tick, 7);
        check("bnc_digit", cap_digit, 9);
        check("bnc_illegal", cap_ill, 0);
        check("bnc_count", cap_pc, 2);
        key_n = 1'b1;
        tick(10);

        // Illegal digit
        sw    = 4'd12;
        key_n = 1'b0;
        clear_mon();
        tick(12);
        check("ill_pulses", pulses, 1);
        check("ill_digit", cap_digit, 12);
        check("ill_flag", cap_ill, 1);
        check("ill_count", cap_pc, 3);
        check("ill_flag_held", int'(digit_illegal), 1);
        key_n = 1'b1;
        tick(10);

        // Hold, then release with a glitch
        sw    = 4'd5;
        key_n = 1'b0;
        clear_mon();
        tick(50);
        check("hold_pulses", pulses, 1);
        check("hold_digit", cap_digit, 5);
        check("hold_illegal", cap_ill, 0);
        check("hold_count", cap_pc, 4);
        clear_mon();
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(1);
        key_n = 1'b1;
        tick(10);
        check("rel_glitch_pulses", pulses, 0);
        tick(4);

        // Saturation after a fresh reset
        reset = 1'b0;
        tick(2);
        check_zero("sat_rst");
        reset = 1'b1;
        tick(6);
        for (int k = 1; k <= 8; k++) begin
            sw    = 4'(k);
            key_n = 1'b0;
            clear_mon();
            tick(10);
            key_n = 1'b1;
            tick(10);
            check($sformatf("sat%0d_pulses", k), pulses, 1);
            check($sformatf("sat%0d_digit", k), cap_digit, k);
            check($sformatf("sat%0d_count", k), cap_pc, (k < 6) ? k : 6);
        end

        // Reset while in PRESS_CHK with the key still held
        sw    = 4'd7;
        key_n = 1'b0;
        clear_mon();
        tick(4);
        reset = 1'b0;
        tick(2);
        check_zero("mid_rst");
        reset = 1'b1;
        tick(20);
        check("held_pulses", pulses, 0);
        check_zero("held");
        key_n = 1'b1;
        tick(6);
        check("held_rel_pulses", pulses, 0);
        key_n = 1'b0;
        clear_mon();
        tick(12);
        check("repress_pulses", pulses, 1);
        check("repress_latency", first_tick, 7);
        check("repress_digit", cap_digit, 7);
        check("repress_count", cap_pc, 1);
        key_n = 1'b1;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lock_digit_entry.md
# lock_digit_entry

Debounced digit-entry stage that sits directly upstream of the combination-lock FSM on the board. It runs on the fast board clock, synchronizes the raw active-low pushbutton and the 4-bit switch bank, and debounces the button. For each clean press it emits a one-cycle strobe carrying the switch value captured at that moment and a legality flag. The lock FSM advances on that strobe instead of on a raw KEY edge.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable synced samples required to accept a press or a release (20 ms at 50 MHz). Minimum 2.
- CNT_W, 20: debounce counter width. DEBOUNCE_CYCLES ≤ 2^CNT_W.
- clk  input  1  board clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- key_n  input  1  raw pushbutton, 0 = pressed, asynchronous and bouncing.
- sw  input  4  raw switch value, asynchronous.
- digit  output  4  switch value captured at the accepted press; held until the next accepted press.
- digit_valid  output  1  one-cycle strobe per accepted press.
- digit_illegal  output  1  registered with digit: 1 when digit > 9.
- press_count  output  3  accepted presses since reset; saturates at 6.

## Operation
- Synchronizers:
  - key_n passes through a 2-flop synchronizer to give key_s. Both flops reset to 1 (released).
  - sw passes through a 2-flop synchronizer to give sw_s. Both flops reset to 0.
- The FSM has four states: IDLE, PRESS_CHK, HELD and REL_CHK. cnt is the debounce counter.
  - IDLE: if key_s==0, go to PRESS_CHK with cnt←0.
  - PRESS_CHK:
    - If key_s==1 (bounce), go to IDLE with cnt←0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HELD with digit←sw_s, digit_illegal←(sw_s>9), digit_valid←1 and press_count←min(press_count+1,6).
    - Else cnt←cnt+1.
  - HELD: if key_s==1, go to REL_CHK with cnt←0. There is no auto-repeat.
  - REL_CHK:
    - If key_s==0 (bounce), return to HELD.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt←cnt+1.
- digit_valid is 1 only in the cycle after the HELD transition, and is 0 in every other cycle.
- Reset state is REL_CHK with cnt=0. A button held through reset therefore produces no digit. The first press is accepted only after DEBOUNCE_CYCLES stable released samples.
- Reset values: digit=0, digit_valid=0, digit_illegal=0, press_count=0, cnt=0.
- Reset has priority over every transition. If reset is applied mid-PRESS_CHK, no strobe is produced.
- cnt never wraps. It is cleared on every state entry that needs counting.

## Timing
- Press latency:
  - E0 is the first rising edge that samples key_n==0.
  - key_s goes low after E1, and the FSM enters PRESS_CHK at E2.
  - digit_valid is high for the cycle following edge E(DEBOUNCE_CYCLES+2), and low again after E(DEBOUNCE_CYCLES+3).
  - This requires key_n to stay low throughout.
- digit, digit_illegal and press_count update at the same edge that raises digit_valid. They are stable while digit_valid is high.
- sw must be stable for ≥3 cycles before the accepting edge, otherwise the captured value is the old or new value, unspecified.
- A bounce (key_s high for any cycle) during PRESS_CHK restarts the full debounce window from the next low sample.
- A press followed by a release each needs DEBOUNCE_CYCLES. The minimum spacing between strobes is 2·DEBOUNCE_CYCLES+2 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset and first press:
  - Stimulus: reset=0 for 2 cycles with key_n=1; then reset=1, key_n=1 for 6 cycles; then sw=3, key_n=0 for 12 cycles.
  - Response: all outputs 0 during reset. One digit_valid pulse after edge E6 with digit=3, digit_illegal=0, press_count=1. No further pulse.
- Press bounce:
  - Stimulus: key_n low 3 cycles, high 1 cycle, then low steady, with sw=9.
  - Response: exactly one strobe, 6 edges after the last falling sample. digit=9, digit_illegal=0.
- Illegal digit:
  - Stimulus: sw=12, clean press.
  - Response: digit=12, digit_illegal=1, one strobe.
- Hold and release bounce:
  - Stimulus: hold key_n=0 for 50 cycles; release with pattern high 2, low 1, high 10.
  - Response: only the initial strobe. The glitch returns the FSM to HELD and produces no second strobe.
- Saturation:
  - Stimulus: 8 clean presses with sw=1..8, each press and release held ≥8 cycles.
  - Response: 8 strobes, digit follows sw each time. press_count steps 1 through 6, then stays at 6.
- Reset while held:
  - Stimulus: assert reset=0 while in PRESS_CHK with key_n=0; deassert reset with key still held for 20 cycles; then release for 6 cycles and press again.
  - Response: no strobe until after the re-press. Outputs read 0 through the hold. The first strobe after reset has press_count=1.
